// File: rtl/uart_pkg.sv
// Shared UART constants and FSM encodings, common to the Rx and Tx sides.
// Parity helper keeps even/odd selection identical on both ends of the link.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Expected parity bit for a word whose XOR reduction is data_xor.
  function automatic logic uart_parity_bit(input logic data_xor, input logic odd);
    return data_xor ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; 2 Clock latency.
// Resets to 1 so a released reset never looks like a start bit.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled mid-bit sampling, LSB-first, one stop bit, no backpressure.
// Optional parity bit compiled in with macro UART_RX_PARITY_EN; results update at mid-stop.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic                  RxIn,
  input  logic                  ParityType,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DoneFlag,
  output logic                  ParityError,
  output logic                  FrameError,
  output logic                  Busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  logic w_rx_sync;

  uart_state_t           r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_done;
  logic                  r_ferr;
  logic                  r_busy;

`ifdef UART_RX_PARITY_EN
  logic r_par_pend;
  logic r_perr;
`else
  logic w_unused_parity_type;
  assign w_unused_parity_type = ParityType;
`endif

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_clk (Clock),
    .i_rst (Reset),
    .i_d   (RxIn),
    .o_q   (w_rx_sync)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_pend <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // Start detection is the only transition allowed on a Tick-less cycle.
        ST_IDLE: begin
          if (!w_rx_sync) begin
            r_state <= ST_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (Tick) begin
            if (r_cnt == HALF_M1) begin
              r_cnt <= '0;
              r_idx <= '0;
              if (!w_rx_sync) begin
                r_state <= ST_DATA;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end

        ST_DATA: begin
          if (Tick) begin
            if (r_cnt == FULL_M1) begin
              r_cnt   <= '0;
              r_shift <= {w_rx_sync, r_shift[DATA_WIDTH-1:1]};
              r_idx   <= r_idx + IW'(1);
              if (r_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_STOP;
`endif
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        // Mismatch is held pending and only published with the rest of the frame.
        ST_PARITY: begin
          if (Tick) begin
            if (r_cnt == FULL_M1) begin
              r_cnt      <= '0;
              r_par_pend <= w_rx_sync ^ uart_parity_bit(^r_shift, ParityType);
              r_state    <= ST_STOP;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
`endif

        ST_STOP: begin
          if (Tick) begin
            if (r_cnt == FULL_M1) begin
              r_cnt   <= '0;
              r_data  <= r_shift;
              r_ferr  <= ~w_rx_sync;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              r_perr  <= r_par_pend;
`endif
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign DataOut    = r_data;
  assign DoneFlag   = r_done;
  assign FrameError = r_ferr;
  assign Busy       = r_busy;

`ifdef UART_RX_PARITY_EN
  assign ParityError = r_perr;
`else
  assign ParityError = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: Tick every 4 Clocks, 16x oversampling, 64 Clocks per bit.
// Parity frames and expectations follow UART_RX_PARITY_EN when it is defined.
module tb_uart_rx_core;

  localparam int OS   = 16;
  localparam int TDIV = 4;
  localparam int BITC = OS * TDIV;
`ifdef UART_RX_PARITY_EN
  localparam logic PE_ON = 1'b1;
`else
  localparam logic PE_ON = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Tick  = 1'b0;
  logic       RxIn  = 1'b1;
  logic       ParityType = 1'b0;
  logic [7:0] DataOut;
  logic       DoneFlag;
  logic       ParityError;
  logic       FrameError;
  logic       Busy;

  int         n_pass    = 0;
  int         n_total   = 0;
  int         done_cnt  = 0;
  int         done_long = 0;
  int         tdiv      = 0;
  logic       prev_done = 1'b0;
  logic [7:0] cap [0:31];

  uart_rx_core #(
    .DATA_WIDTH (8),
    .OVERSAMPLE (OS)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Tick        (Tick),
    .RxIn        (RxIn),
    .ParityType  (ParityType),
    .DataOut     (DataOut),
    .DoneFlag    (DoneFlag),
    .ParityError (ParityError),
    .FrameError  (FrameError),
    .Busy        (Busy)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    tdiv <= (tdiv == TDIV - 1) ? 0 : tdiv + 1;
    Tick <= (tdiv == TDIV - 1);
  end

  // Record every DoneFlag pulse and the word presented with it.
  always @(negedge Clock) begin
    if (DoneFlag) begin
      if (done_cnt < 32) cap[done_cnt] = DataOut;
      done_cnt = done_cnt + 1;
      if (prev_done) done_long = done_long + 1;
    end
    prev_done = DoneFlag;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b, input int n);
    RxIn = b;
    repeat (n) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_ok);
    send_bit(1'b0, BITC);
    for (int i = 0; i < 8; i++) send_bit(d[i], BITC);
`ifdef UART_RX_PARITY_EN
    send_bit(pbit, BITC);
`else
    if (pbit === 1'bx) send_bit(1'b1, 1);
`endif
    if (stop_ok) begin
      send_bit(1'b1, BITC);
    end else begin
      send_bit(1'b0, 40);
      send_bit(1'b1, BITC - 40);
    end
  endtask

  initial begin
    int d0;
    logic [7:0] abort_word;

    repeat (3) @(negedge Clock);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(DoneFlag), 0);
    chk("rst_data", 32'(DataOut), 0);
    chk("rst_perr", 32'(ParityError), 0);
    chk("rst_ferr", 32'(FrameError), 0);
    Reset = 1'b0;
    repeat (10) @(negedge Clock);

    // 0xA5: four ones, even parity bit 0
    d0 = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (16) @(negedge Clock);
    chk("a5_done", 32'(done_cnt - d0), 1);
    chk("a5_data", 32'(DataOut), 32'hA5);
    chk("a5_perr", 32'(ParityError), 0);
    chk("a5_ferr", 32'(FrameError), 0);
    chk("a5_busy", 32'(Busy), 0);

    // 0x3C: four ones, parity bit deliberately sent as 1
    d0 = done_cnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (16) @(negedge Clock);
    chk("3c_done", 32'(done_cnt - d0), 1);
    chk("3c_data", 32'(DataOut), 32'h3C);
    chk("3c_perr", 32'(ParityError), 32'(PE_ON));
    chk("3c_ferr", 32'(FrameError), 0);

    // 0x81: two ones, correct parity, stop bit low
    d0 = done_cnt;
    send_frame(8'h81, 1'b0, 1'b0);
    repeat (16) @(negedge Clock);
    chk("81_done", 32'(done_cnt - d0), 1);
    chk("81_data", 32'(DataOut), 32'h81);
    chk("81_ferr", 32'(FrameError), 1);
    chk("81_perr", 32'(ParityError), 0);

    // Start glitch: low for 4 Ticks only
    d0 = done_cnt;
    send_bit(1'b0, 4 * TDIV);
    send_bit(1'b1, 2 * BITC);
    chk("gl_done", 32'(done_cnt - d0), 0);
    chk("gl_busy", 32'(Busy), 0);
    chk("gl_data", 32'(DataOut), 32'h81);
    chk("gl_ferr", 32'(FrameError), 1);

    // Reset in the middle of data bit 3
    d0 = done_cnt;
    abort_word = 8'hC3;
    send_bit(1'b0, BITC);
    for (int i = 0; i < 3; i++) send_bit(abort_word[i], BITC);
    send_bit(abort_word[3], BITC / 2);
    chk("mid_busy", 32'(Busy), 1);
    Reset = 1'b1;
    RxIn  = 1'b1;
    repeat (2) @(negedge Clock);
    chk("rstm_busy", 32'(Busy), 0);
    chk("rstm_data", 32'(DataOut), 0);
    chk("rstm_ferr", 32'(FrameError), 0);
    Reset = 1'b0;
    send_bit(1'b1, 3 * BITC);
    chk("rstm_done", 32'(done_cnt - d0), 0);
    chk("rstm_idle", 32'(Busy), 0);

    // 0x5A with odd parity: four ones, parity bit 1
    ParityType = 1'b1;
    d0 = done_cnt;
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (16) @(negedge Clock);
    chk("5a_done", 32'(done_cnt - d0), 1);
    chk("5a_data", 32'(DataOut), 32'h5A);
    chk("5a_perr", 32'(ParityError), 0);
    chk("5a_ferr", 32'(FrameError), 0);
    ParityType = 1'b0;

    // Back-to-back 0xFF then 0x00 with no idle gap
    d0 = done_cnt;
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1);
    repeat (16) @(negedge Clock);
    chk("b2b_done", 32'(done_cnt - d0), 2);
    chk("b2b_first", 32'(cap[d0 % 32]), 32'hFF);
    chk("b2b_second", 32'(cap[(d0 + 1) % 32]), 32'h00);
    chk("b2b_data", 32'(DataOut), 32'h00);
    chk("b2b_perr", 32'(ParityError), 0);
    chk("done_width", 32'(done_long), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
